// File: rtl/dcache_wb_top.sv
// dcache_wb_top: direct-mapped, write-back, write-allocate data cache with a
// built-in backing memory whose block transfers take MEM_LATENCY cycles.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   MemRead      read request
//   MemWrite     write request (wins when both are high)
//   WordAddress  word address, split as {tag, index, offset}
//   DataIn       write data
//   ByteEn       per-byte write enables (ignored on reads)
//   DataOut      read data, valid when MemRead=1 and stall=0
//   stall        core must hold its request inputs while high
//
// Optional build macro DCACHE_PERF_CNT_EN adds saturating 32-bit counters
// hit_count, miss_count and wb_count as extra outputs.
module dcache_wb_top #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned NUM_LINES       = 32,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [ADDR_W-1:0]   WordAddress,
  input  logic [DATA_W-1:0]   DataIn,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic [DATA_W-1:0]   DataOut,
  output logic                stall
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         wb_count
`endif
);

  localparam int unsigned OFF_W     = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IDX_W     = $clog2(NUM_LINES);
  localparam int unsigned TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W     = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_arr    [NUM_LINES];
  logic [DATA_W-1:0]    cache_data [NUM_LINES*WORDS_PER_BLOCK];
  logic [DATA_W-1:0]    mem        [MEM_DEPTH];
  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [OFF_W-1:0] addr_off;
  logic             req;
  logic             hit;
  logic             idle;
  logic             wr_hit;
  logic             cnt_last;

  assign addr_tag = WordAddress[ADDR_W-1 -: TAG_W];
  assign addr_idx = WordAddress[OFF_W +: IDX_W];
  assign addr_off = WordAddress[OFF_W-1:0];
  assign req      = MemRead | MemWrite;
  assign hit      = valid[addr_idx] && (tag_arr[addr_idx] == addr_tag);
  assign idle     = (state == IDLE);
  assign wr_hit   = idle && MemWrite && hit;
  assign cnt_last = (cnt == CNT_LAST);

  // Outputs are forced quiet while reset is held, even with a request present.
  always_comb begin
    stall   = 1'b0;
    DataOut = '0;
    if (rst) begin
      stall = !idle || (req && !hit);
      if (idle && MemRead && hit)
        DataOut = cache_data[{addr_idx, addr_off}];
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // Marks the single IDLE cycle right after a refill so that hit is not counted.
  logic refilled;
`endif

  // Control state, valid/dirty bits and backing memory (all cleared on reset).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      valid   <= '0;
      dirty   <= '0;
      req_tag <= '0;
      req_idx <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
`ifdef DCACHE_PERF_CNT_EN
      refilled   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef DCACHE_PERF_CNT_EN
          refilled <= 1'b0;
          if (req && hit && !refilled && hit_count != '1)
            hit_count <= hit_count + 32'd1;
          if (req && !hit && miss_count != '1)
            miss_count <= miss_count + 32'd1;
`endif
          if (req && !hit) begin
            req_tag <= addr_tag;
            req_idx <= addr_idx;
            cnt     <= '0;
            state   <= (valid[addr_idx] && dirty[addr_idx]) ? WRITEBACK : REFILL;
          end else if (wr_hit) begin
            dirty[addr_idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (cnt_last) begin
            for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++)
              mem[{tag_arr[req_idx], req_idx, OFF_W'(w)}] <= cache_data[{req_idx, OFF_W'(w)}];
            dirty[req_idx] <= 1'b0;
            cnt            <= '0;
            state          <= REFILL;
`ifdef DCACHE_PERF_CNT_EN
            if (wb_count != '1) wb_count <= wb_count + 32'd1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REFILL: begin
          if (cnt_last) begin
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
            cnt            <= '0;
            state          <= IDLE;
`ifdef DCACHE_PERF_CNT_EN
            refilled <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Cache data and tags need no reset: valid=0 masks them, and a reset forces
  // the FSM back to IDLE, so an aborted refill never lands here.
  always_ff @(posedge clk) begin
    if (state == REFILL && cnt_last) begin
      tag_arr[req_idx] <= req_tag;
      for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++)
        cache_data[{req_idx, OFF_W'(w)}] <= mem[{req_tag, req_idx, OFF_W'(w)}];
    end else if (wr_hit) begin
      for (int unsigned b = 0; b < BE_W; b++)
        if (ByteEn[b])
          cache_data[{addr_idx, addr_off}][b*8 +: 8] <= DataIn[b*8 +: 8];
    end
  end

endmodule
